iob_wishbone_mem_slave: RTL and testbench

Wishbone B3 slave memory model that answers the DMA master port of the Ethernet MAC simulation wrapper (`m_wb_*`). It is the responding end of the Ethernet MAC's buffer-descriptor and frame-data transfers. It supports:
- classic single cycles with programmable wait states;
- incrementing-linear bursts (`cti`/`bte`);
- error responses for out-of-range or unsupported accesses.

Used in bench and FPGA bring-up wherever a real memory controller is absent.

---
 rtl/iob_wishbone_mem_slave.sv | 153 +++++++++++++++
 tb/tb_iob_wishbone_mem_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iob_wishbone_mem_slave.sv
// Wishbone B3 slave memory model answering the Ethernet MAC DMA master port.
// Supports classic cycles with programmable wait states, incrementing-linear bursts and error responses.
module iob_wishbone_mem_slave #(
   parameter int                MEM_ADDR_W  = 12,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic [2:0]          wb_cti_i,
   input  logic [1:0]          wb_bte_i,
   output logic                wb_ack_o,
   output logic                wb_err_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_BEAT  = 3'd2;
   localparam logic [2:0] ST_BURST = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam int            MEM_DEPTH   = 1 << MEM_ADDR_W;
   localparam logic [3:0]    WAIT_LOAD   = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
   localparam logic [ADDR_W:0] DEPTH_WORDS = (ADDR_W + 1)'(1) << MEM_ADDR_W;

   logic [2:0]        state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] cur_adr;
   logic              cur_we;
   logic [2:0]        cur_cti;
   logic              cur_wrap;

   logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

   logic [ADDR_W-1:0]     acc_off;
   logic [MEM_ADDR_W-1:0] acc_idx;
   logic                  acc_in_range;
   logic                  acc_bad_type;
   logic                  acc_valid;
   logic                  acc_fault;
   logic                  acc_ack;
   logic                  acc_err;
   logic                  acc_we;
   logic [ADDR_W:0]       adr_inc;

   // One access is resolved per edge, in BEAT (latched request) or BURST (live strobe).
   always_comb begin
      acc_off      = cur_adr - BASE_ADDR;
      acc_idx      = acc_off[MEM_ADDR_W+1:2];
      acc_in_range = (cur_adr >= BASE_ADDR) && !cur_wrap &&
                     ({1'b0, acc_off >> 2} < DEPTH_WORDS);
      acc_bad_type = (state == ST_BEAT) &&
                     (((cur_cti == CTI_INCR) && (wb_bte_i != 2'b00)) ||
                      !(cur_cti inside {CTI_CLASSIC, CTI_INCR, CTI_END}));
      acc_valid    = wb_rst_n_i && wb_cyc_i &&
                     ((state == ST_BEAT) || ((state == ST_BURST) && wb_stb_i));
      acc_fault    = !acc_in_range || acc_bad_type;
      acc_ack      = acc_valid && !acc_fault;
      acc_err      = acc_valid && acc_fault;
      acc_we       = (state == ST_BURST) ? wb_we_i : cur_we;
      adr_inc      = {1'b0, cur_adr} + (ADDR_W + 1)'(4);
   end

   // NOTE: the storage array has no reset branch on purpose; contents survive reset and
   // a reset on the whole array would also stop it mapping onto block RAM.
   always_ff @(posedge wb_clk_i) begin
      if (acc_ack && acc_we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (wb_sel_i[b]) mem[acc_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         cur_adr  <= '0;
         cur_we   <= 1'b0;
         cur_cti  <= CTI_CLASSIC;
         cur_wrap <= 1'b0;
      end else begin
         wb_ack_o <= acc_ack;
         wb_err_o <= acc_err;
         if (acc_ack && !acc_we) wb_dat_o <= mem[acc_idx];

         if (!wb_cyc_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (wb_stb_i) begin
                     cur_adr  <= wb_adr_i;
                     cur_we   <= wb_we_i;
                     cur_cti  <= wb_cti_i;
                     cur_wrap <= 1'b0;
                     if (WAIT_STATES > 0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                     end else begin
                        state <= ST_BEAT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (wait_cnt == 4'd0) state <= ST_BEAT;
                  else                  wait_cnt <= wait_cnt - 4'd1;
               end
               ST_BEAT: begin
                  if (acc_ack && (cur_cti == CTI_INCR)) begin
                     state    <= ST_BURST;
                     cur_adr  <= adr_inc[ADDR_W-1:0];
                     cur_wrap <= adr_inc[ADDR_W];
                  end else begin
                     state <= ST_GAP;
                  end
               end
               ST_BURST: begin
                  // A dropped strobe inside the burst just holds the address.
                  if (wb_stb_i) begin
                     if (acc_err || (wb_cti_i == CTI_END)) begin
                        state <= ST_GAP;
                     end else begin
                        cur_adr  <= adr_inc[ADDR_W-1:0];
                        cur_wrap <= cur_wrap | adr_inc[ADDR_W];
                     end
                  end
               end
               ST_GAP:  state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iob_wishbone_mem_slave.sv
// Directed bench for iob_wishbone_mem_slave: one instance with no wait states, one with three.
// Shared bus signals; use3 routes cyc/stb to, and observes, the selected instance.
module tb_iob_wishbone_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic        we, cyc, stb, use3;
   logic [2:0]  cti;
   logic [1:0]  bte;

   logic [31:0] dat_o0, dat_o3;
   logic        ack0, err0, ack3, err3;
   logic        cyc0, stb0, cyc3, stb3;
   logic        ack, err;
   logic [31:0] rd;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign cyc0 = cyc & ~use3;
   assign stb0 = stb & ~use3;
   assign cyc3 = cyc & use3;
   assign stb3 = stb & use3;
   assign ack  = use3 ? ack3   : ack0;
   assign err  = use3 ? err3   : err0;
   assign rd   = use3 ? dat_o3 : dat_o0;

   iob_wishbone_mem_slave #(.WAIT_STATES(0)) dut0 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
      .wb_dat_o(dat_o0), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc0),
      .wb_stb_i(stb0), .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack0),
      .wb_err_o(err0)
   );

   iob_wishbone_mem_slave #(.WAIT_STATES(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
      .wb_dat_o(dat_o3), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc3),
      .wb_stb_i(stb3), .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack3),
      .wb_err_o(err3)
   );

   task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Latency counts edges from the one that samples the request to the one that raises ack/err.
   task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input int lat, input logic exp_err,
                          input logic [31:0] exp_rd, input string tag);
      int   n;
      logic seen;
      adr = a; we = w; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
      cyc = 1'b1; stb = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (ack || err) seen = 1'b1;
      end
      check(32'(n), 32'(lat), {tag, " latency"});
      check(32'(ack), 32'(!exp_err), {tag, " ack"});
      check(32'(err), 32'(exp_err), {tag, " err"});
      if (!w && !exp_err) check(rd, exp_rd, {tag, " rdata"});
      // Master registered: strobe still high one edge after ack.
      tick();
      check(32'(ack | err), 32'd0, {tag, " single pulse"});
      cyc = 1'b0; stb = 1'b0;
      tick();
      check(32'(ack | err), 32'd0, {tag, " idle after"});
   endtask

   task automatic burst(input logic [31:0] a, input logic w, input int len, input int ws,
                        input string tag);
      adr = a; we = w; sel = 4'hF; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      for (int k = 0; k < len; k++) begin
         dat = 32'(k + 1);
         cti = (k == len - 1) ? 3'b111 : 3'b010;
         if (k == 0) begin
            repeat (ws + 1) begin
               tick();
               check(32'(ack | err), 32'd0, $sformatf("%s pre-beat quiet", tag));
            end
         end
         tick();
         check(32'(ack), 32'd1, $sformatf("%s beat%0d ack", tag, k));
         check(32'(err), 32'd0, $sformatf("%s beat%0d err", tag, k));
         if (!w) check(rd, 32'(k + 1), $sformatf("%s beat%0d rdata", tag, k));
         adr = 32'hFFFF_0000;
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      check(32'(ack | err), 32'd0, {tag, " tail quiet"});
   endtask

   initial begin
      use3 = 1'b0; rst_n = 1'b0;
      adr = 32'h100; dat = '0; sel = 4'hF; we = 1'b0; cti = 3'b000; bte = 2'b00;
      cyc = 1'b1; stb = 1'b1;

      // Reset held with a live request: no response.
      repeat (3) begin
         tick();
         check(32'(ack0), 32'd0, "reset ack");
         check(32'(err0), 32'd0, "reset err");
      end
      cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
      tick();
      check(32'(ack0), 32'd0, "post-reset ack0");
      check(32'(err0), 32'd0, "post-reset err0");
      check(dat_o0, 32'd0, "post-reset dat_o0");
      check(32'(ack3), 32'd0, "post-reset ack3");
      check(32'(err3), 32'd0, "post-reset err3");
      check(dat_o3, 32'd0, "post-reset dat_o3");

      // No wait states: classic write then read.
      classic(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0, "ws0 write");
      classic(32'h100, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF, "ws0 read");

      // Three wait states: partial byte write over a full word.
      use3 = 1'b1;
      classic(32'h40, 1'b1, 32'h11223344, 4'hF, 5, 1'b0, 32'h0, "ws3 write full");
      classic(32'h40, 1'b1, 32'h0000AB00, 4'b0010, 5, 1'b0, 32'h0, "ws3 write byte1");
      classic(32'h40, 1'b0, 32'h0, 4'hF, 5, 1'b0, 32'h1122AB44, "ws3 read");

      // Incrementing bursts.
      use3 = 1'b0;
      burst(32'h200, 1'b1, 4, 0, "burst write");
      burst(32'h200, 1'b0, 4, 0, "burst read");

      // Out-of-range classic read: first byte address past the array.
      classic(32'h4000, 1'b0, 32'h0, 4'hF, 2, 1'b1, 32'h0, "oor read");

      // Burst with unsupported bte: single err, no write.
      adr = 32'h200; we = 1'b1; dat = 32'hBAD0BAD0; sel = 4'hF;
      cti = 3'b010; bte = 2'b01; cyc = 1'b1; stb = 1'b1;
      tick();
      tick();
      check(32'(err), 32'd1, "bte burst err");
      check(32'(ack), 32'd0, "bte burst ack");
      cyc = 1'b0; stb = 1'b0; bte = 2'b00;
      tick();
      check(32'(ack | err), 32'd0, "bte burst quiet");
      classic(32'h200, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'd1, "bte unchanged w0");
      classic(32'h204, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'd2, "bte unchanged w1");

      // Cycle dropped during wait states of a write.
      use3 = 1'b1;
      adr = 32'h40; we = 1'b1; dat = 32'hFFFFFFFF; sel = 4'hF; cti = 3'b000;
      cyc = 1'b1; stb = 1'b1;
      tick();
      tick();
      check(32'(ack | err), 32'd0, "abort in wait");
      cyc = 1'b0; stb = 1'b0;
      repeat (4) begin
         tick();
         check(32'(ack | err), 32'd0, "abort quiet");
      end
      classic(32'h40, 1'b0, 32'h0, 4'hF, 5, 1'b0, 32'h1122AB44, "abort old value");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
